// File: rtl/ud_count_decoder_pkg.sv
// Shared types and default sizing for the up/down count decoder slice.
package ud_count_decoder_pkg;

  localparam int DEF_WIDTH     = 5;
  localparam int DEF_STEP_W    = 16;
  localparam int DEF_ERR_LIMIT = 3;

  // Tracking state of the decoder against the observed counter.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOST    = 2'd3
  } state_e;

  // Meaning of one sampled transition prev -> count.
  typedef enum logic [2:0] {
    CLS_HOLD    = 3'd0,
    CLS_UP      = 3'd1,
    CLS_DOWN    = 3'd2,
    CLS_RESET   = 3'd3,
    CLS_ILLEGAL = 3'd4
  } cls_e;

endpackage

// File: rtl/ud_count_decoder_if.sv
// Count-observation bus: the sampled counter value in, decoded status out.
interface ud_count_decoder_if #(
  parameter int WIDTH  = 5,
  parameter int STEP_W = 16
);

  logic [WIDTH-1:0]  count_in;
  logic              sample_en;
  logic              dir_up;
  logic              locked;
  logic              step_pulse;
  logic              wrap_pulse;
  logic              rst_pulse;
  logic              err_pulse;
  logic [STEP_W-1:0] step_count;

  // Producer side: supplies counter samples, consumes status.
  modport master (
    output count_in, sample_en,
    input  dir_up, locked, step_pulse, wrap_pulse, rst_pulse, err_pulse, step_count
  );

  // Decoder side: consumes counter samples, produces status.
  modport slave (
    input  count_in, sample_en,
    output dir_up, locked, step_pulse, wrap_pulse, rst_pulse, err_pulse, step_count
  );

endinterface

// File: rtl/ud_step_classifier.sv
// Combinational classifier for one counter transition prev -> count.
module ud_step_classifier
  import ud_count_decoder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] prev_i,
  input  logic [WIDTH-1:0] count_i,
  output cls_e             cls_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] delta;

  // +1/-1 checks come before the jump-to-zero check, so 31->0 and 1->0 stay steps.
  always_comb begin
    delta  = count_i - prev_i;
    cls_o  = CLS_ILLEGAL;
    wrap_o = 1'b0;
    if (delta == '0) begin
      cls_o = CLS_HOLD;
    end else if (delta == WIDTH'(1)) begin
      cls_o  = CLS_UP;
      wrap_o = (count_i == '0);
    end else if (delta == '1) begin
      cls_o  = CLS_DOWN;
      wrap_o = (count_i == '1);
    end else if (count_i == '0) begin
      cls_o = CLS_RESET;
    end
  end

endmodule

// File: rtl/ud_count_decoder.sv
// Observes an up/down counter's output and decodes direction, steps, wraps,
// counter resets and illegal jumps, with a lock/lost tracking state machine.
module ud_count_decoder
  import ud_count_decoder_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int STEP_W    = DEF_STEP_W,
  parameter int ERR_LIMIT = DEF_ERR_LIMIT
) (
  input logic              clk,
  input logic              reset,
  ud_count_decoder_if.slave bus
);

  localparam int ERR_W = $clog2(ERR_LIMIT + 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic              dir_q, dir_d;
  logic [STEP_W-1:0] stepCount_q, stepCount_d;
  logic [ERR_W-1:0]  errCount_q, errCount_d;
  logic              pend_q, pend_d;
  logic              pendUp_q, pendUp_d;
  logic              stepPulse_q, stepPulse_d;
  logic              wrapPulse_q, wrapPulse_d;
  logic              rstPulse_q, rstPulse_d;
  logic              errPulse_q, errPulse_d;

  cls_e cls;
  logic clsWrap;
  logic isStep;
  logic isUp;

  ud_step_classifier #(.WIDTH(WIDTH)) u_classifier (
    .prev_i  (prev_q),
    .count_i (bus.count_in),
    .cls_o   (cls),
    .wrap_o  (clsWrap)
  );

  assign isStep = (cls == CLS_UP) || (cls == CLS_DOWN);
  assign isUp   = (cls == CLS_UP);

  // Next-state decision, taken only on cycles where a sample is presented.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    dir_d       = dir_q;
    stepCount_d = stepCount_q;
    errCount_d  = errCount_q;
    pend_d      = pend_q;
    pendUp_d    = pendUp_q;
    stepPulse_d = 1'b0;
    wrapPulse_d = 1'b0;
    rstPulse_d  = 1'b0;
    errPulse_d  = 1'b0;
    if (bus.sample_en) begin
      prev_d = bus.count_in;
      if (state_q == ST_IDLE) begin
        state_d = ST_ACQUIRE;
      end else if (isStep && (state_q == ST_LOST) && !(pend_q && (pendUp_q == isUp))) begin
        // First step after losing lock only arms the relock check.
        pend_d   = 1'b1;
        pendUp_d = isUp;
        dir_d    = isUp;
      end else begin
        case (cls)
          CLS_UP, CLS_DOWN: begin
            state_d     = ST_LOCKED;
            dir_d       = isUp;
            stepPulse_d = 1'b1;
            wrapPulse_d = clsWrap;
            stepCount_d = isUp ? stepCount_q + 1'b1 : stepCount_q - 1'b1;
            errCount_d  = '0;
            pend_d      = 1'b0;
          end
          CLS_HOLD: begin
            if (state_q == ST_LOCKED) errCount_d = '0;
            pend_d = 1'b0;
          end
          CLS_RESET: begin
            state_d     = ST_ACQUIRE;
            rstPulse_d  = 1'b1;
            stepCount_d = '0;
            errCount_d  = '0;
            pend_d      = 1'b0;
          end
          default: begin
            errPulse_d = 1'b1;
            pend_d     = 1'b0;
            if (state_q == ST_LOCKED) begin
              if (int'(errCount_q) + 1 >= ERR_LIMIT) begin
                state_d    = ST_LOST;
                errCount_d = '0;
              end else begin
                errCount_d = errCount_q + 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  // State and registered outputs, cleared immediately by the async reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      prev_q      <= '0;
      dir_q       <= 1'b0;
      stepCount_q <= '0;
      errCount_q  <= '0;
      pend_q      <= 1'b0;
      pendUp_q    <= 1'b0;
      stepPulse_q <= 1'b0;
      wrapPulse_q <= 1'b0;
      rstPulse_q  <= 1'b0;
      errPulse_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      dir_q       <= dir_d;
      stepCount_q <= stepCount_d;
      errCount_q  <= errCount_d;
      pend_q      <= pend_d;
      pendUp_q    <= pendUp_d;
      stepPulse_q <= stepPulse_d;
      wrapPulse_q <= wrapPulse_d;
      rstPulse_q  <= rstPulse_d;
      errPulse_q  <= errPulse_d;
    end
  end

  assign bus.dir_up     = dir_q;
  assign bus.locked     = (state_q == ST_LOCKED);
  assign bus.step_pulse = stepPulse_q;
  assign bus.wrap_pulse = wrapPulse_q;
  assign bus.rst_pulse  = rstPulse_q;
  assign bus.err_pulse  = errPulse_q;
  assign bus.step_count = stepCount_q;

endmodule

// File: tb/tb_ud_count_decoder.sv
// Self-checking bench for ud_count_decoder against an arithmetic reference model.
module tb_ud_count_decoder;

  localparam int MOD = 32;

  localparam int M_IDLE = 0;
  localparam int M_ACQ  = 1;
  localparam int M_LOCK = 2;
  localparam int M_LOST = 3;

  logic clk;
  logic reset;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int mState;
  int mPrev;
  bit mDir;
  int mCount;
  int mErrs;
  bit mPend;
  bit mPendUp;
  bit eStep, eWrap, eRst, eErr;

  ud_count_decoder_if #(.WIDTH(5), .STEP_W(16)) bus ();

  ud_count_decoder #(.WIDTH(5), .STEP_W(16), .ERR_LIMIT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 10 ns free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [21:0] obsVec();
    return {bus.dir_up, bus.locked, bus.step_pulse, bus.wrap_pulse,
            bus.rst_pulse, bus.err_pulse, bus.step_count};
  endfunction

  function automatic logic [21:0] expVec();
    logic [15:0] c;
    c = mCount[15:0];
    return {mDir, (mState == M_LOCK), eStep, eWrap, eRst, eErr, c};
  endfunction

  task automatic modelReset();
    mState = M_IDLE; mPrev = 0; mDir = 1'b0; mCount = 0; mErrs = 0;
    mPend = 1'b0; mPendUp = 1'b0;
    eStep = 1'b0; eWrap = 1'b0; eRst = 1'b0; eErr = 1'b0;
  endtask

  // Applies the decoding rules to one presented sample.
  task automatic modelSample(input bit en, input int v);
    int d;
    bit up, dn;
    eStep = 1'b0; eWrap = 1'b0; eRst = 1'b0; eErr = 1'b0;
    if (!en) return;
    d  = (v - mPrev + MOD) % MOD;
    up = (d == 1);
    dn = (d == MOD - 1);
    if (mState == M_IDLE) begin
      mState = M_ACQ;
    end else if (up || dn) begin
      if (mState == M_LOST && !(mPend && mPendUp == up)) begin
        mPend = 1'b1; mPendUp = up; mDir = up;
      end else begin
        mState = M_LOCK; mPend = 1'b0; mErrs = 0; mDir = up;
        eStep = 1'b1;
        eWrap = up ? (v == 0) : (v == MOD - 1);
        mCount = (mCount + (up ? 1 : -1)) & 16'hFFFF;
      end
    end else if (d == 0) begin
      if (mState == M_LOCK) mErrs = 0;
      mPend = 1'b0;
    end else if (v == 0) begin
      eRst = 1'b1; mCount = 0; mState = M_ACQ; mErrs = 0; mPend = 1'b0;
    end else begin
      eErr = 1'b1; mPend = 1'b0;
      if (mState == M_LOCK) begin
        mErrs++;
        if (mErrs >= 3) begin
          mState = M_LOST; mErrs = 0;
        end
      end
    end
    mPrev = v;
  endtask

  // Presents one sample, lets one clock edge pass and advances the model.
  task automatic applyStimulus(input bit en, input int v);
    bus.count_in  = 5'(v);
    bus.sample_en = en;
    @(posedge clk);
    #1;
    modelSample(en, v);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.count_in = '0;
    bus.sample_en = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obsVec() !== 22'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", obsVec(), 22'd0);
    end
    reset = 1'b1;
  endtask

  task automatic test_count_up();
    int vals[4] = '{0, 1, 2, 3};
    int seen = 0;
    foreach (vals[i]) begin
      applyStimulus(1'b1, vals[i]);
      seen += int'(bus.step_pulse);
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL count_up[%0d]: got %h expected %h", i, obsVec(), expVec());
      end
    end
    checks++;
    if (seen != 3 || bus.step_count !== 16'd3 || bus.dir_up !== 1'b1 || bus.locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL count_up_summary: got steps=%0d count=%0d dir=%b lock=%b expected 3 3 1 1",
               seen, bus.step_count, bus.dir_up, bus.locked);
    end
  endtask

  task automatic test_wrap_up();
    int vals[5] = '{29, 30, 31, 0, 1};
    int wraps = 0;
    int errp = 0;
    logic [15:0] start;
    foreach (vals[i]) begin
      applyStimulus(1'b1, vals[i]);
      if (i == 0) start = bus.step_count;
      else begin
        wraps += int'(bus.wrap_pulse);
        errp  += int'(bus.err_pulse);
      end
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL wrap_up[%0d]: got %h expected %h", i, obsVec(), expVec());
      end
    end
    checks++;
    if (wraps != 1 || errp != 0 || bus.step_count !== start + 16'd4 || bus.dir_up !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_up_summary: got wraps=%0d errs=%0d delta=%0d dir=%b expected 1 0 4 1",
               wraps, errp, bus.step_count - start, bus.dir_up);
    end
  endtask

  task automatic test_down_reset();
    int vals[6] = '{5, 4, 3, 0, 31, 30};
    foreach (vals[i]) begin
      applyStimulus(1'b1, vals[i]);
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL down_reset[%0d]: got %h expected %h", i, obsVec(), expVec());
      end
      if (i == 3) begin
        checks++;
        if (bus.rst_pulse !== 1'b1 || bus.step_count !== 16'd0 || bus.locked !== 1'b0) begin
          errors++;
          $display("[TB] FAIL counter_reset: got rst=%b count=%0d lock=%b expected 1 0 0",
                   bus.rst_pulse, bus.step_count, bus.locked);
        end
      end
      if (i == 4) begin
        checks++;
        if (bus.wrap_pulse !== 1'b1 || bus.locked !== 1'b1 || bus.dir_up !== 1'b0) begin
          errors++;
          $display("[TB] FAIL down_wrap: got wrap=%b lock=%b dir=%b expected 1 1 0",
                   bus.wrap_pulse, bus.locked, bus.dir_up);
        end
      end
    end
    checks++;
    if (bus.step_count !== 16'hFFFE) begin
      errors++;
      $display("[TB] FAIL down_count: got %h expected fffe", bus.step_count);
    end
  endtask

  task automatic test_illegal_lost();
    int vals[7] = '{10, 11, 20, 7, 15, 16, 17};
    int errp = 0;
    foreach (vals[i]) begin
      applyStimulus(1'b1, vals[i]);
      if (i >= 2 && i <= 4) errp += int'(bus.err_pulse);
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL illegal_lost[%0d]: got %h expected %h", i, obsVec(), expVec());
      end
      if (i == 4) begin
        checks++;
        if (errp != 3 || bus.locked !== 1'b0) begin
          errors++;
          $display("[TB] FAIL lost_entry: got errs=%0d lock=%b expected 3 0", errp, bus.locked);
        end
      end
      if (i == 5) begin
        checks++;
        if (bus.step_pulse !== 1'b0 || bus.locked !== 1'b0) begin
          errors++;
          $display("[TB] FAIL relock_first: got step=%b lock=%b expected 0 0", bus.step_pulse, bus.locked);
        end
      end
    end
    checks++;
    if (bus.step_pulse !== 1'b1 || bus.locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL relock_second: got step=%b lock=%b expected 1 1", bus.step_pulse, bus.locked);
    end
  endtask

  task automatic test_sample_disabled();
    logic [21:0] held;
    applyStimulus(1'b0, 0);
    held = expVec();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, (i % 2 == 0) ? 31 : 9);
      checks++;
      if (obsVec() !== held || obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL sample_disabled[%0d]: got %h expected %h", i, obsVec(), held);
      end
    end
  endtask

  task automatic test_async_reset();
    reset = 1'b0;
    modelReset();
    #2;
    checks++;
    if (obsVec() !== 22'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h expected %h", obsVec(), 22'd0);
    end
    #1;
    reset = 1'b1;
    applyStimulus(1'b1, 7);
    checks++;
    if (obsVec() !== 22'd0 || obsVec() !== expVec()) begin
      errors++;
      $display("[TB] FAIL post_reset_first: got %h expected %h", obsVec(), 22'd0);
    end
    applyStimulus(1'b1, 8);
    checks++;
    if (obsVec() !== expVec()) begin
      errors++;
      $display("[TB] FAIL post_reset_step: got %h expected %h", obsVec(), expVec());
    end
  endtask

  task automatic test_random();
    int r;
    int v;
    bit en;
    for (int i = 0; i < 400; i++) begin
      r  = int'($urandom_range(0, 99));
      en = ($urandom_range(0, 9) != 0);
      if (r < 40)      v = (mPrev + 1) % MOD;
      else if (r < 70) v = (mPrev + MOD - 1) % MOD;
      else if (r < 78) v = mPrev;
      else if (r < 84) v = 0;
      else             v = int'($urandom_range(0, MOD - 1));
      applyStimulus(en, v);
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL random[%0d]: got %h expected %h", i, obsVec(), expVec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_up();
    test_down_reset();
    test_illegal_lost();
    test_sample_disabled();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
